fir_upsampler_n: RTL and testbench

FIR_UPSAMPLER_N -- requirements
Module: fir_upsampler_n

---
 rtl/fir_upsampler_n.sv | 238 +++++++++++++++++++++++
 tb/tb_fir_upsampler_n.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_upsampler_n.sv
// rtl/fir_upsampler_n.sv - 2x chroma upsampler: 6-tap symmetric FIR interpolation over interleaved channels
module fir_upsampler_n #(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 2,
   parameter int LINE_LEN = 160,
   parameter int C0       = 21,
   parameter int C1       = 52,
   parameter int C2       = 159
) (
   input  logic                                           CLOCK_50_I,
   input  logic                                           reset,
   input  logic                                           line_start,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [2*DATA_W-1:0]                            in_data,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
   output logic [DATA_W-1:0]                              out_even,
   output logic [DATA_W-1:0]                              out_odd,
   output logic                                           out_last,
   output logic                                           busy
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ACC_W = 2 * DATA_W + 4;
   localparam int J_W   = $clog2(LINE_LEN);
   localparam int TOTAL = NUM_CH * LINE_LEN / 2;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam logic signed [ACC_W-1:0] K0   = ACC_W'(C0);
   localparam logic signed [ACC_W-1:0] K1   = ACC_W'(C1);
   localparam logic signed [ACC_W-1:0] K2   = ACC_W'(C2);
   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(128);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << DATA_W) - 1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_MAC0, S_MAC1, S_MAC2, S_OUT} state_t;

   state_t                    state_q;
   logic [J_W-1:0]            j_q;
   logic [CH_W-1:0]           ch_q;
   logic [CH_W-1:0]           wr_ch_q;
   logic [CNT_W-1:0]          wr_cnt_q;
   logic signed [ACC_W-1:0]   acc_q;
   // win_q[c][0..5] holds x[j-2..j+3] of channel c
   logic [DATA_W-1:0]         win_q [NUM_CH][6];
   logic [2*DATA_W-1:0]       buf_q [NUM_CH];
   logic [1:0]                buf_n_q [NUM_CH];
   logic [1:0]                init_n_q [NUM_CH];
   logic [NUM_CH-1:0]         owe_q;
   logic [CH_W-1:0]           out_ch_q;
   logic [DATA_W-1:0]         out_even_q;
   logic [DATA_W-1:0]         out_odd_q;
   logic                      out_last_q;

   logic [CH_W-1:0]           wr_dst;
   logic [1:0]                dst_init;
   logic                      dst_buf_full;
   logic [CNT_W-1:0]          base_cnt;
   logic                      words_left;
   logic                      accept;
   logic                      all_ready;
   logic                      all_can_shift;
   logic                      rep;
   logic                      last_ch;
   logic [DATA_W-1:0]         nxt [NUM_CH];
   logic signed [ACC_W-1:0]   acc_d;
   logic signed [ACC_W-1:0]   shifted;
   logic [DATA_W-1:0]         odd_d;

   function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
      ext = $signed({{(ACC_W-DATA_W){1'b0}}, v});
   endfunction

   // Input side: a line_start word is word 0 of a freshly cleared line
   always_comb begin
      wr_dst       = line_start ? '0 : wr_ch_q;
      dst_init     = line_start ? 2'd0 : init_n_q[wr_dst];
      dst_buf_full = line_start ? 1'b0 : (buf_n_q[wr_dst] != 2'd0);
      base_cnt     = line_start ? '0 : wr_cnt_q;
      words_left   = line_start || (wr_cnt_q < CNT_W'(TOTAL));
      in_ready     = !reset && (state_q != S_IDLE || line_start) && words_left &&
                     (dst_init != 2'd2 || !dst_buf_full);
      accept       = in_valid && in_ready;
   end

   // Window readiness and next-sample selection from each pending buffer
   always_comb begin
      all_ready     = 1'b1;
      all_can_shift = 1'b1;
      rep           = (int'(j_q) + 4 >= LINE_LEN);
      last_ch       = (ch_q == CH_W'(NUM_CH - 1));
      for (int c = 0; c < NUM_CH; c++) begin
         nxt[c] = (buf_n_q[c] == 2'd2) ? buf_q[c][2*DATA_W-1:DATA_W] : buf_q[c][DATA_W-1:0];
         if (init_n_q[c] != 2'd2 || owe_q[c]) all_ready = 1'b0;
         if (!rep && buf_n_q[c] == 2'd0) all_can_shift = 1'b0;
      end
   end

   // One symmetric tap pair per MAC state, then round/shift/clip for the odd sample
   always_comb begin
      acc_d = acc_q;
      case (state_q)
         S_MAC0:  acc_d = K0 * (ext(win_q[ch_q][0]) + ext(win_q[ch_q][5])) + RND;
         S_MAC1:  acc_d = acc_q - K1 * (ext(win_q[ch_q][1]) + ext(win_q[ch_q][4]));
         S_MAC2:  acc_d = acc_q + K2 * (ext(win_q[ch_q][2]) + ext(win_q[ch_q][3]));
         default: acc_d = acc_q;
      endcase
      shifted = acc_d >>> 8;
      if (shifted < 0)         odd_d = '0;
      else if (shifted > MAXV) odd_d = '1;
      else                     odd_d = shifted[DATA_W-1:0];
   end

   // Control FSM plus window/buffer bookkeeping; line_start and accepted words override last
   always_ff @(posedge CLOCK_50_I or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         j_q        <= '0;
         ch_q       <= '0;
         wr_ch_q    <= '0;
         wr_cnt_q   <= '0;
         acc_q      <= '0;
         owe_q      <= '0;
         out_ch_q   <= '0;
         out_even_q <= '0;
         out_odd_q  <= '0;
         out_last_q <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            buf_q[c]    <= '0;
            buf_n_q[c]  <= '0;
            init_n_q[c] <= '0;
            for (int k = 0; k < 6; k++) win_q[c][k] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: ;
            S_FILL: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  if (owe_q[c] && buf_n_q[c] != 2'd0) begin
                     for (int k = 0; k < 5; k++) win_q[c][k] <= win_q[c][k+1];
                     win_q[c][5] <= nxt[c];
                     buf_n_q[c]  <= buf_n_q[c] - 2'd1;
                     owe_q[c]    <= 1'b0;
                  end
               end
               if (all_ready) state_q <= S_MAC0;
            end
            S_MAC0: begin
               acc_q   <= acc_d;
               state_q <= S_MAC1;
            end
            S_MAC1: begin
               acc_q   <= acc_d;
               state_q <= S_MAC2;
            end
            S_MAC2: begin
               acc_q      <= acc_d;
               out_odd_q  <= odd_d;
               out_even_q <= win_q[ch_q][2];
               out_ch_q   <= ch_q;
               out_last_q <= (j_q == J_W'(LINE_LEN - 1)) && last_ch;
               state_q    <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q <= S_IDLE;
                  end else if (!last_ch) begin
                     ch_q    <= ch_q + CH_W'(1);
                     state_q <= S_MAC0;
                  end else begin
                     ch_q <= '0;
                     j_q  <= j_q + J_W'(1);
                     // Past the line end the last sample is replicated by keeping slot 5
                     for (int c = 0; c < NUM_CH; c++) begin
                        if (rep) begin
                           for (int k = 0; k < 5; k++) win_q[c][k] <= win_q[c][k+1];
                        end else if (buf_n_q[c] != 2'd0) begin
                           for (int k = 0; k < 5; k++) win_q[c][k] <= win_q[c][k+1];
                           win_q[c][5] <= nxt[c];
                           buf_n_q[c]  <= buf_n_q[c] - 2'd1;
                        end else begin
                           owe_q[c] <= 1'b1;
                        end
                     end
                     state_q <= all_can_shift ? S_MAC0 : S_FILL;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (line_start) begin
            state_q    <= S_FILL;
            j_q        <= '0;
            ch_q       <= '0;
            wr_ch_q    <= '0;
            wr_cnt_q   <= '0;
            owe_q      <= '0;
            out_last_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
               buf_q[c]    <= '0;
               buf_n_q[c]  <= '0;
               init_n_q[c] <= '0;
               for (int k = 0; k < 6; k++) win_q[c][k] <= '0;
            end
         end

         // First two words of a channel seed the window with left-edge replication
         if (accept) begin
            if (dst_init == 2'd0) begin
               win_q[wr_dst][0]  <= in_data[2*DATA_W-1:DATA_W];
               win_q[wr_dst][1]  <= in_data[2*DATA_W-1:DATA_W];
               win_q[wr_dst][2]  <= in_data[2*DATA_W-1:DATA_W];
               win_q[wr_dst][3]  <= in_data[DATA_W-1:0];
               init_n_q[wr_dst]  <= 2'd1;
            end else if (dst_init == 2'd1) begin
               win_q[wr_dst][4]  <= in_data[2*DATA_W-1:DATA_W];
               win_q[wr_dst][5]  <= in_data[DATA_W-1:0];
               init_n_q[wr_dst]  <= 2'd2;
            end else begin
               buf_q[wr_dst]     <= in_data;
               buf_n_q[wr_dst]   <= 2'd2;
            end
            wr_ch_q  <= (wr_dst == CH_W'(NUM_CH - 1)) ? '0 : wr_dst + CH_W'(1);
            wr_cnt_q <= base_cnt + CNT_W'(1);
         end
      end
   end

   assign out_valid = (state_q == S_OUT);
   assign busy      = (state_q != S_IDLE);
   assign out_ch    = out_ch_q;
   assign out_even  = out_even_q;
   assign out_odd   = out_odd_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_fir_upsampler_n.sv
// tb/tb_fir_upsampler_n.sv - directed self-checking bench for fir_upsampler_n
module tb_fir_upsampler_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, ls_a, iv_a, ir_a, ov_a, or_a, ol_a, busy_a;
   logic [15:0] id_a;
   logic [0:0]  och_a;
   logic [7:0]  oe_a, oo_a;

   logic        rst_b, ls_b, iv_b, ir_b, ov_b, or_b, ol_b, busy_b;
   logic [15:0] id_b;
   logic [0:0]  och_b;
   logic [7:0]  oe_b, oo_b;

   fir_upsampler_n #(.DATA_W(8), .NUM_CH(1), .LINE_LEN(8)) u_a (
      .CLOCK_50_I(clk), .reset(rst_a), .line_start(ls_a), .in_valid(iv_a), .in_ready(ir_a),
      .in_data(id_a), .out_valid(ov_a), .out_ready(or_a), .out_ch(och_a), .out_even(oe_a),
      .out_odd(oo_a), .out_last(ol_a), .busy(busy_a));

   fir_upsampler_n #(.DATA_W(8), .NUM_CH(2), .LINE_LEN(8)) u_b (
      .CLOCK_50_I(clk), .reset(rst_b), .line_start(ls_b), .in_valid(iv_b), .in_ready(ir_b),
      .in_data(id_b), .out_valid(ov_b), .out_ready(or_b), .out_ch(och_b), .out_even(oe_b),
      .out_odd(oo_b), .out_last(ol_b), .busy(busy_b));

   int checks = 0;
   int errors = 0;

   logic [7:0] xa [8];
   logic [7:0] rb [8];
   logic [7:0] qb [8];
   logic [7:0] ev [16];
   logic [7:0] od [16];
   logic       lst [16];
   logic [0:0] chs [16];
   int         np;

   task automatic load_a(input logic [63:0] v);
      for (int i = 0; i < 8; i++) xa[i] = v[63-8*i -: 8];
   endtask

   // Run one line on DUT a with out_ready=1; stop after max_pairs pairs or out_last
   task automatic run_line_a(input int max_pairs);
      int  widx;
      bit  done;
      @(posedge clk); #1;
      ls_a = 1'b1; iv_a = 1'b1; id_a = {xa[0], xa[1]}; or_a = 1'b1;
      widx = 0; np = 0; done = 1'b0;
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge clk);
         if (iv_a && ir_a) widx++;
         if (ov_a && or_a) begin
            ev[np] = oe_a; od[np] = oo_a; lst[np] = ol_a; chs[np] = och_a; np++;
            if (ol_a || np >= max_pairs) done = 1'b1;
         end
         if (!done) begin
            @(posedge clk); #1;
            ls_a = 1'b0;
            iv_a = (widx < 4);
            if (widx < 4) id_a = {xa[2*widx], xa[2*widx+1]};
         end
      end
      ls_a = 1'b0; iv_a = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL run_a_timeout got %0d pairs required %0d", np, max_pairs);
      end
   endtask

   task automatic test_reset;
      rst_a = 1'b1; rst_b = 1'b1; ls_a = 1'b1; iv_a = 1'b1; id_a = 16'hffff; or_a = 1'b1;
      ls_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ir_a, ov_a, ol_a, busy_a, och_a, oe_a, oo_a} !== 21'd0) begin
         errors++; $display("FAIL reset_a got %h required 0", {ir_a, ov_a, ol_a, busy_a, och_a, oe_a, oo_a});
      end
      checks++;
      if ({ir_b, ov_b, ol_b, busy_b, och_b, oe_b, oo_b} !== 21'd0) begin
         errors++; $display("FAIL reset_b got %h required 0", {ir_b, ov_b, ol_b, busy_b, och_b, oe_b, oo_b});
      end
      @(posedge clk); #1;
      rst_a = 1'b0; rst_b = 1'b0; ls_a = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if ({ir_a, busy_a, ov_a} !== 3'b000) begin
            errors++; $display("FAIL idle_no_start got %b required 000", {ir_a, busy_a, ov_a});
         end
      end
      iv_a = 1'b0;
   endtask

   task automatic test_flat;
      load_a({8{8'd100}});
      run_line_a(8);
      checks++;
      if (np != 8) begin errors++; $display("FAIL flat_count got %0d required 8", np); end
      for (int p = 0; p < 8; p++) begin
         checks++;
         if (ev[p] !== 8'd100 || od[p] !== 8'd100) begin
            errors++; $display("FAIL flat_pair%0d got %0d/%0d required 100/100", p, ev[p], od[p]);
         end
         checks++;
         if (lst[p] !== (p == 7)) begin
            errors++; $display("FAIL flat_last%0d got %b required %b", p, lst[p], (p == 7));
         end
      end
   endtask

   task automatic test_lines;
      load_a({8'd40, 8'd80, 8'd120, 8'd160, 8'd200, 8'd240, 8'd255, 8'd255});
      run_line_a(8);
      checks++;
      if (np != 8) begin errors++; $display("FAIL line1_count got %0d required 8", np); end
      for (int p = 0; p < 8; p++) begin
         checks++;
         if (ev[p] !== xa[p]) begin
            errors++; $display("FAIL line1_even%0d got %0d required %0d", p, ev[p], xa[p]);
         end
      end
      checks++; if (od[0] !== 8'd58)  begin errors++; $display("FAIL line1_odd0 got %0d required 58", od[0]); end
      checks++; if (od[1] !== 8'd103) begin errors++; $display("FAIL line1_odd1 got %0d required 103", od[1]); end
      checks++; if (od[7] !== 8'd254) begin errors++; $display("FAIL line1_odd7 got %0d required 254", od[7]); end

      load_a({8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70});
      run_line_a(8);
      checks++; if (od[0] !== 8'd5)  begin errors++; $display("FAIL ramp_odd0 got %0d required 5", od[0]); end
      checks++; if (od[2] !== 8'd25) begin errors++; $display("FAIL ramp_odd2 got %0d required 25", od[2]); end
      checks++; if (od[7] !== 8'd70) begin errors++; $display("FAIL ramp_odd7 got %0d required 70", od[7]); end
      checks++; if (ev[5] !== 8'd50) begin errors++; $display("FAIL ramp_even5 got %0d required 50", ev[5]); end
   endtask

   task automatic test_clip;
      load_a({8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0});
      run_line_a(8);
      checks++; if (od[2] !== 8'd255) begin errors++; $display("FAIL clip_high got %0d required 255", od[2]); end
      load_a({8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255});
      run_line_a(8);
      checks++; if (od[2] !== 8'd0) begin errors++; $display("FAIL clip_low got %0d required 0", od[2]); end
   endtask

   task automatic test_restart;
      load_a({8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70});
      run_line_a(3);
      load_a({8'd40, 8'd80, 8'd120, 8'd160, 8'd200, 8'd240, 8'd255, 8'd255});
      run_line_a(8);
      checks++;
      if (np != 8 || lst[7] !== 1'b1) begin
         errors++; $display("FAIL restart_count got %0d required 8", np);
      end
      checks++;
      if (ev[0] !== 8'd40 || od[0] !== 8'd58) begin
         errors++; $display("FAIL restart_first got %0d/%0d required 40/58", ev[0], od[0]);
      end
      checks++;
      if (ev[3] !== 8'd160) begin errors++; $display("FAIL restart_even3 got %0d required 160", ev[3]); end
   endtask

   task automatic test_reset_mid;
      load_a({8'd0, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70});
      run_line_a(2);
      @(posedge clk); #1;
      rst_a = 1'b1; iv_a = 1'b1;
      @(negedge clk);
      checks++;
      if ({ir_a, ov_a, ol_a, busy_a, och_a, oe_a, oo_a} !== 21'd0) begin
         errors++; $display("FAIL reset_mid got %h required 0", {ir_a, ov_a, ol_a, busy_a, och_a, oe_a, oo_a});
      end
      @(posedge clk); #1;
      rst_a = 1'b0;
      repeat (8) begin
         @(negedge clk);
         checks++;
         if ({ov_a, ir_a, busy_a} !== 3'b000) begin
            errors++; $display("FAIL post_reset_wait got %b required 000", {ov_a, ir_a, busy_a});
         end
      end
      iv_a = 1'b0;
      load_a({8{8'd100}});
      run_line_a(8);
      checks++;
      if (np != 8 || ev[0] !== 8'd100 || od[0] !== 8'd100 || lst[7] !== 1'b1) begin
         errors++; $display("FAIL post_reset_line got %0d pairs first %0d/%0d required 8 pairs 100/100", np, ev[0], od[0]);
      end
   endtask

   task automatic test_backpressure;
      int widx, stall;
      bit done, saw_block;
      for (int i = 0; i < 8; i++) rb[i] = 8'(10 * i);
      qb[0] = 8'd40;  qb[1] = 8'd80;  qb[2] = 8'd120; qb[3] = 8'd160;
      qb[4] = 8'd200; qb[5] = 8'd240; qb[6] = 8'd255; qb[7] = 8'd255;
      @(posedge clk); #1;
      ls_b = 1'b1; iv_b = 1'b1; id_b = {rb[0], rb[1]}; or_b = 1'b0;
      widx = 0; stall = 0; np = 0; done = 1'b0; saw_block = 1'b0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         if (iv_b && ir_b) widx++;
         else if (iv_b && !ir_b) saw_block = 1'b1;
         if (ov_b && !or_b) begin
            checks++;
            if ({och_b, oe_b, oo_b, ol_b} !== {1'b0, 8'd0, 8'd5, 1'b0}) begin
               errors++; $display("FAIL stall_hold got ch%0d %0d/%0d last%b required ch0 0/5 last0",
                                  och_b, oe_b, oo_b, ol_b);
            end
            stall++;
         end
         if (ov_b && or_b) begin
            ev[np] = oe_b; od[np] = oo_b; lst[np] = ol_b; chs[np] = och_b; np++;
            if (ol_b || np >= 16) done = 1'b1;
         end
         if (!done) begin
            @(posedge clk); #1;
            ls_b = 1'b0;
            or_b = (stall >= 10);
            iv_b = (widx < 8);
            if (widx < 8) id_b = (widx % 2 == 0) ? {rb[widx/2*2], rb[widx/2*2+1]}
                                                 : {qb[widx/2*2], qb[widx/2*2+1]};
         end
      end
      iv_b = 1'b0;
      checks++; if (stall != 10) begin errors++; $display("FAIL stall_cycles got %0d required 10", stall); end
      checks++; if (!saw_block) begin errors++; $display("FAIL in_ready_block got 0 required 1"); end
      checks++; if (np != 16) begin errors++; $display("FAIL bp_count got %0d required 16", np); end
      for (int p = 0; p < np && p < 16; p++) begin
         checks++;
         if (chs[p] !== 1'(p % 2)) begin
            errors++; $display("FAIL bp_ch%0d got %0d required %0d", p, chs[p], p % 2);
         end
         checks++;
         if (ev[p] !== ((p % 2 == 0) ? rb[p/2] : qb[p/2])) begin
            errors++; $display("FAIL bp_even%0d got %0d required %0d", p, ev[p], (p % 2 == 0) ? rb[p/2] : qb[p/2]);
         end
         checks++;
         if (lst[p] !== (p == 15)) begin
            errors++; $display("FAIL bp_last%0d got %b required %b", p, lst[p], (p == 15));
         end
      end
      checks++; if (od[0]  !== 8'd5)   begin errors++; $display("FAIL bp_odd0 got %0d required 5", od[0]); end
      checks++; if (od[4]  !== 8'd25)  begin errors++; $display("FAIL bp_odd4 got %0d required 25", od[4]); end
      checks++; if (od[14] !== 8'd70)  begin errors++; $display("FAIL bp_odd14 got %0d required 70", od[14]); end
      checks++; if (od[1]  !== 8'd58)  begin errors++; $display("FAIL bp_odd1 got %0d required 58", od[1]); end
      checks++; if (od[3]  !== 8'd103) begin errors++; $display("FAIL bp_odd3 got %0d required 103", od[3]); end
      checks++; if (od[15] !== 8'd254) begin errors++; $display("FAIL bp_odd15 got %0d required 254", od[15]); end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_lines();
      test_clip();
      test_restart();
      test_reset_mid();
      test_backpressure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
